// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU control definitions. Holds the ALU operation
//                codes, the operation-class codes from the main decoder,
//                the funct3 selectors and a funct7 classification helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation class driven by the main decoder
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_OP     = 2'b10;
    localparam logic [1:0] ALUOP_OPIMM  = 2'b11;

    // ALU operation codes; 1010-1111 are reserved and never produced
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctrl_e;

    // funct3 selectors shared by OP and OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // The only two funct7 encodings the base integer ISA defines
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // True only for a defined funct7 encoding. Written as a case so an
    // unknown funct7 falls to the default and yields a clean 0.
    function automatic logic funct7_is_std(input logic [6:0] f7);
        logic r;
        r = 1'b0;
        case (f7)
            F7_BASE, F7_ALT: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    // True only when funct7 is exactly the base encoding
    function automatic logic funct7_is_base(input logic [6:0] f7);
        logic r;
        r = 1'b0;
        case (f7)
            F7_BASE: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_decode
//  Description : Purely combinational ALU control decode. Maps the
//                operation class, funct3 and funct7 to an ALU operation
//                code and flags unsupported funct7 encodings. Every
//                decision is a case with an ADD / legal default so that
//                unknown inputs never leak X onto the outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int CTRL_W = 4    // only 4 is supported
) (
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal
);

    alu_ctrl_e ctrl_d;
    logic      illegal_d;
    logic      f7_std;
    logic      f7_base;

    assign f7_std  = funct7_is_std(funct7);
    assign f7_base = funct7_is_base(funct7);

    // Operation code selection from class, funct3 and funct7[5]
    always_comb begin
        ctrl_d = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:    ctrl_d = ALU_ADD;
            ALUOP_BRANCH: ctrl_d = ALU_SUB;
            ALUOP_OP, ALUOP_OPIMM: begin
                case (funct3)
                    F3_ADD: begin
                        // Immediate form has no subtract; funct7 holds imm bits
                        if (alu_op == ALUOP_OP) begin
                            case (funct7[5])
                                1'b1:    ctrl_d = ALU_SUB;
                                default: ctrl_d = ALU_ADD;
                            endcase
                        end else begin
                            ctrl_d = ALU_ADD;
                        end
                    end
                    F3_SLL:  ctrl_d = ALU_SLL;
                    F3_SLT:  ctrl_d = ALU_SLT;
                    F3_SLTU: ctrl_d = ALU_SLTU;
                    F3_XOR:  ctrl_d = ALU_XOR;
                    F3_SR: begin
                        case (funct7[5])
                            1'b1:    ctrl_d = ALU_SRA;
                            default: ctrl_d = ALU_SRL;
                        endcase
                    end
                    F3_OR:   ctrl_d = ALU_OR;
                    F3_AND:  ctrl_d = ALU_AND;
                    default: ctrl_d = ALU_ADD;
                endcase
            end
            default: ctrl_d = ALU_ADD;
        endcase
    end

    // Unsupported funct7 detection for register and immediate forms
    always_comb begin
        illegal_d = 1'b0;
        case (alu_op)
            ALUOP_OP: begin
                if (!f7_std) begin
                    illegal_d = 1'b1;
                end else if (!f7_base) begin
                    // Alternate encoding only exists for SUB and SRA
                    case (funct3)
                        F3_ADD, F3_SR: illegal_d = 1'b0;
                        default:       illegal_d = 1'b1;
                    endcase
                end
            end
            ALUOP_OPIMM: begin
                // Only the shift immediates carry a funct7 field
                case (funct3)
                    F3_SLL:  illegal_d = !f7_base;
                    F3_SR:   illegal_d = !f7_std;
                    default: illegal_d = 1'b0;
                endcase
            end
            default: illegal_d = 1'b0;
        endcase
    end

    assign alu_ctrl = CTRL_W'(ctrl_d);
    assign illegal  = illegal_d;

endmodule : alu_ctrl_decode
`default_nettype wire

// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
//  Module      : alu_control
//  Description : ALU control unit. Wraps the combinational decode and adds
//                one-cycle registered copies of the operation code and the
//                illegal flag. Reset only clears the registered copies.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_control
    import alu_pkg::*;
#(
    parameter int CTRL_W = 4    // only 4 is supported
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic [CTRL_W-1:0] alu_ctrl_q,
    output logic              illegal_q
);

    logic [CTRL_W-1:0] alu_ctrl_d;
    logic              illegal_d;

    alu_ctrl_decode #(
        .CTRL_W (CTRL_W)
    ) u_decode (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_ctrl (alu_ctrl_d),
        .illegal  (illegal_d)
    );

    assign alu_ctrl = alu_ctrl_d;
    assign illegal  = illegal_d;

    // Registered copies; reset wins over the incoming decode
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_ctrl_q <= CTRL_W'(ALU_ADD);
            illegal_q  <= 1'b0;
        end else begin
            alu_ctrl_q <= alu_ctrl_d;
            illegal_q  <= illegal_d;
        end
    end

endmodule : alu_control
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_control
//  Description : Self-checking bench for alu_control. Directed vectors for
//                the documented cases plus randomized stimulus compared to
//                a table-driven reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alu_ctrl;
    logic       illegal;
    logic [3:0] alu_ctrl_q;
    logic       illegal_q;

    int n_tests = 0;
    int n_fail  = 0;

    alu_control #(
        .CTRL_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7     (funct7),
        .alu_ctrl   (alu_ctrl),
        .illegal    (illegal),
        .alu_ctrl_q (alu_ctrl_q),
        .illegal_q  (illegal_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {illegal, code}. Code per funct3 from a lookup table,
    // then the funct7[5] alternates (SUB for register form, SRA).
    function automatic logic [4:0] ref_model(input logic [1:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7);
        int  tbl [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
        int  code;
        bit  ill;
        bit  std_f7;
        std_f7 = (f7 == 7'd0) || (f7 == 7'd32);
        ill    = 1'b0;
        if (op == 2'd0) begin
            code = 0;
        end else if (op == 2'd1) begin
            code = 1;
        end else begin
            code = tbl[f3];
            if (f3 == 3'd0 && op == 2'd2 && f7[5]) code = 1;
            if (f3 == 3'd5 && f7[5]) code = 9;
            if (op == 2'd2)
                ill = !std_f7 || (f7 == 7'd32 && f3 != 3'd0 && f3 != 3'd5);
            else
                ill = ((f3 == 3'd1 || f3 == 3'd5) && !std_f7) || (f3 == 3'd1 && f7 == 7'd32);
        end
        return {ill, 4'(code)};
    endfunction

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic r);
        @(negedge clk);
        alu_op = op;
        funct3 = f3;
        funct7 = f7;
        rst    = r;
        #1;
    endtask

    // Directed vector with literal expectations, combinational and registered
    task automatic vec(input string tag, input logic [1:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [3:0] exp_c, input logic exp_i);
        drive(op, f3, f7, 1'b0);
        check({tag, " ctrl"}, 32'(alu_ctrl), 32'(exp_c));
        check({tag, " ill"}, 32'(illegal), 32'(exp_i));
        @(posedge clk);
        #1;
        check({tag, " ctrl_q"}, 32'(alu_ctrl_q), 32'(exp_c));
        check({tag, " ill_q"}, 32'(illegal_q), 32'(exp_i));
    endtask

    initial begin
        logic [4:0] exp;
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       r;

        rst = 1'b1; alu_op = 2'b10; funct3 = 3'b101; funct7 = 7'b0100000;

        // Reset state
        @(posedge clk); #1;
        check("reset ctrl_q", 32'(alu_ctrl_q), 32'h0);
        check("reset ill_q", 32'(illegal_q), 32'h0);
        check("reset comb ctrl", 32'(alu_ctrl), 32'h9);

        // Add / branch classes ignore funct fields
        vec("add ign", 2'b00, 3'b111, 7'b1111111, 4'h0, 1'b0);
        vec("branch",  2'b01, 3'b110, 7'b0100000, 4'h1, 1'b0);

        // Register-form sweep
        vec("op add",  2'b10, 3'b000, 7'b0000000, 4'h0, 1'b0);
        vec("op sub",  2'b10, 3'b000, 7'b0100000, 4'h1, 1'b0);
        vec("op and",  2'b10, 3'b111, 7'b0000000, 4'h2, 1'b0);
        vec("op or",   2'b10, 3'b110, 7'b0000000, 4'h3, 1'b0);
        vec("op xor",  2'b10, 3'b100, 7'b0000000, 4'h4, 1'b0);
        vec("op slt",  2'b10, 3'b010, 7'b0000000, 4'h5, 1'b0);
        vec("op sltu", 2'b10, 3'b011, 7'b0000000, 4'h6, 1'b0);
        vec("op sll",  2'b10, 3'b001, 7'b0000000, 4'h7, 1'b0);
        vec("op srl",  2'b10, 3'b101, 7'b0000000, 4'h8, 1'b0);
        vec("op sra",  2'b10, 3'b101, 7'b0100000, 4'h9, 1'b0);

        // Immediate-form sweep, including no SUBI
        vec("imm add",  2'b11, 3'b000, 7'b0000000, 4'h0, 1'b0);
        vec("imm nosub",2'b11, 3'b000, 7'b0100000, 4'h0, 1'b0);
        vec("imm and",  2'b11, 3'b111, 7'b0000000, 4'h2, 1'b0);
        vec("imm slt",  2'b11, 3'b010, 7'b1010101, 4'h5, 1'b0);
        vec("imm sll",  2'b11, 3'b001, 7'b0000000, 4'h7, 1'b0);
        vec("imm srl",  2'b11, 3'b101, 7'b0000000, 4'h8, 1'b0);
        vec("imm sra",  2'b11, 3'b101, 7'b0100000, 4'h9, 1'b0);

        // Illegal encodings still decode normally
        vec("ill and",   2'b10, 3'b111, 7'b0100000, 4'h2, 1'b1);
        vec("ill op f7", 2'b10, 3'b000, 7'b0000001, 4'h0, 1'b1);
        vec("ill slli",  2'b11, 3'b001, 7'b0100000, 4'h7, 1'b1);
        vec("ill srai",  2'b11, 3'b101, 7'b1100000, 4'h9, 1'b1);

        // Unknown inputs: never X, and ADD whenever the inputs really are unknown
        drive('x, 'x, 'x, 1'b0);
        check("x no-x", 32'($isunknown({alu_ctrl, illegal})), 32'h0);
        exp = ref_model(alu_op, funct3, funct7);
        check("x ctrl", 32'(alu_ctrl),
              $isunknown({alu_op, funct3, funct7}) ? 32'h0 : 32'(exp[3:0]));

        // Reset while SRA selected, then release
        drive(2'b10, 3'b101, 7'b0100000, 1'b0);
        @(posedge clk); #1;
        drive(2'b10, 3'b101, 7'b0100000, 1'b1);
        check("rst comb ctrl", 32'(alu_ctrl), 32'h9);
        @(posedge clk); #1;
        check("rst sra ctrl_q", 32'(alu_ctrl_q), 32'h0);
        drive(2'b10, 3'b101, 7'b0100000, 1'b0);
        @(posedge clk); #1;
        check("rel sra ctrl_q", 32'(alu_ctrl_q), 32'h9);

        // Randomized stimulus against the reference model
        for (int i = 0; i < 500; i++) begin
            op = 2'($urandom_range(0, 3));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       f7 = 7'b0000000;
                1:       f7 = 7'b0100000;
                default: f7 = 7'($urandom);
            endcase
            r = ($urandom_range(0, 7) == 0);
            drive(op, f3, f7, r);
            exp = ref_model(op, f3, f7);
            check($sformatf("rnd%0d ctrl", i), 32'(alu_ctrl), 32'(exp[3:0]));
            check($sformatf("rnd%0d ill", i), 32'(illegal), 32'(exp[4]));
            @(posedge clk); #1;
            check($sformatf("rnd%0d ctrl_q", i), 32'(alu_ctrl_q), r ? 32'h0 : 32'(exp[3:0]));
            check($sformatf("rnd%0d ill_q", i), 32'(illegal_q), r ? 32'h0 : 32'(exp[4]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_control
`default_nettype wire
